jkff_clearn: RTL and testbench



---
 rtl/jkff_clearn.sv | 55 +++++
 tb/tb_jkff_clearn.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/jkff_clearn.sv
// Bank of WIDTH independent JK flip-flops with synchronous active-low clear and complementary outputs.
// Optional synchronous active-low preset input when JKFF_CLEARN_PRESET_EN is defined.
module jkff_clearn #(
    parameter int WIDTH = 1
) (
    input  logic             Clock,
    input  logic             ClearN,
`ifdef JKFF_CLEARN_PRESET_EN
    input  logic             PresetN,
`endif
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN
);

    logic [WIDTH-1:0] q_next;

    // Per-bit case decode rather than the characteristic equation so that
    // a set or reset resolves an unknown power-up state in simulation.
    always_comb begin
        q_next = Q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({J[i], K[i]})
                2'b00:   q_next[i] = Q[i];
                2'b10:   q_next[i] = 1'b1;
                2'b01:   q_next[i] = 1'b0;
                default: q_next[i] = ~Q[i];
            endcase
        end
    end

`ifdef JKFF_CLEARN_PRESET_EN
    always_ff @(posedge Clock) begin
        if (!ClearN) begin
            Q <= '0;
        end else if (!PresetN) begin
            Q <= '1;
        end else begin
            Q <= q_next;
        end
    end
`else
    always_ff @(posedge Clock) begin
        if (!ClearN) begin
            Q <= '0;
        end else begin
            Q <= q_next;
        end
    end
`endif

    assign QN = ~Q;

endmodule

// File: tb/tb_jkff_clearn.sv
// Directed self-checking bench for jkff_clearn: a 1-bit instance for the JK table
// and clear behaviour, and a 4-bit instance for per-bit independence and preset.
module tb_jkff_clearn;

    logic       clk;
    logic       clr_n1;
    logic [0:0] j1, k1, q1, qn1;
    logic       clr_n4;
    logic [3:0] j4, k4, q4, qn4;
`ifdef JKFF_CLEARN_PRESET_EN
    logic       pre_n;
`endif

    int n_total = 0;
    int n_bad   = 0;

    jkff_clearn #(.WIDTH(1)) u_dut1 (
        .Clock  (clk),
        .ClearN (clr_n1),
`ifdef JKFF_CLEARN_PRESET_EN
        .PresetN(1'b1),
`endif
        .J      (j1),
        .K      (k1),
        .Q      (q1),
        .QN     (qn1)
    );

    jkff_clearn #(.WIDTH(4)) u_dut4 (
        .Clock  (clk),
        .ClearN (clr_n4),
`ifdef JKFF_CLEARN_PRESET_EN
        .PresetN(pre_n),
`endif
        .J      (j4),
        .K      (k4),
        .Q      (q4),
        .QN     (qn4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic exp);
        chk({tag, "_q"},  {3'b000, q1},  {3'b000, exp});
        chk({tag, "_qn"}, {3'b000, qn1}, {3'b000, ~exp});
    endtask

    logic tog_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        clr_n1 = 1'b1; j1 = 1'b1; k1 = 1'b0;
        clr_n4 = 1'b0; j4 = 4'b1111; k4 = 4'b1111;
`ifdef JKFF_CLEARN_PRESET_EN
        pre_n = 1'b1;
`endif
        tick();
        chk1("set", 1'b1);
        chk("clr4_q",  q4,  4'b0000);
        chk("clr4_qn", qn4, 4'b1111);

        j1 = 1'b0; k1 = 1'b1;
        tick();
        chk1("reset", 1'b0);

        j1 = 1'b1; k1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1($sformatf("toggle%0d", i), tog_exp[i]);
        end

        j1 = 1'b1; k1 = 1'b0;
        tick();
        j1 = 1'b0; k1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1($sformatf("hold%0d", i), 1'b1);
        end

        // Inputs wiggle between edges; no edge, so Q must not move.
        j1 = 1'b0; k1 = 1'b1;
        #3;
        j1 = 1'b1; k1 = 1'b1;
        #2;
        chk1("no_edge", 1'b1);
        j1 = 1'b0; k1 = 1'b0;
        tick();
        chk1("hold_after_wiggle", 1'b1);

        clr_n1 = 1'b0; j1 = 1'b1; k1 = 1'b1;
        #2;
        chk1("clr_before_edge", 1'b1);
        tick();
        chk1("clr_edge", 1'b0);
        tick();
        chk1("clr_held0", 1'b0);
        tick();
        chk1("clr_held1", 1'b0);

        clr_n1 = 1'b1; j1 = 1'b1; k1 = 1'b0;
        tick();
        chk1("set_after_clr", 1'b1);

        j1 = 1'b1; k1 = 1'b1;
        tick();
        chk1("tog_a", 1'b0);
        tick();
        chk1("tog_b", 1'b1);
        clr_n1 = 1'b0;
        tick();
        chk1("clr_mid_toggle", 1'b0);

        clr_n4 = 1'b1; j4 = 4'b0011; k4 = 4'b1100;
        tick();
        chk("w4_init_q", q4, 4'b0011);
        j4 = 4'b1010; k4 = 4'b0110;
        tick();
        chk("w4_mix_q",  q4,  4'b1001);
        chk("w4_mix_qn", qn4, 4'b0110);
        j4 = 4'b0110; k4 = 4'b1001;
        tick();
        chk("w4_mix2_q", q4, 4'b0110);

`ifdef JKFF_CLEARN_PRESET_EN
        pre_n = 1'b0; j4 = 4'b0000; k4 = 4'b1111;
        tick();
        chk("w4_preset_q",  q4,  4'b1111);
        chk("w4_preset_qn", qn4, 4'b0000);
        clr_n4 = 1'b0;
        tick();
        chk("w4_clr_over_preset", q4, 4'b0000);
        clr_n4 = 1'b1; pre_n = 1'b1; j4 = 4'b0101; k4 = 4'b0000;
        tick();
        chk("w4_after_preset", q4, 4'b0101);
`else
        clr_n4 = 1'b0;
        tick();
        chk("w4_clr_q", q4, 4'b0000);
        clr_n4 = 1'b1; j4 = 4'b0101; k4 = 4'b0000;
        tick();
        chk("w4_after_clr", q4, 4'b0101);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
